// File: rtl/vx_tlb_ptw.sv
// Sv32-style page-table walker: one walk in flight, PTE reads over a
// valid/ready memory port, translations out on the TLB update channel.
`ifndef XLEN
`define XLEN 32
`endif

module vx_tlb_ptw #(
  parameter int unsigned LEVELS       = 2,
  parameter int unsigned VPN_SEG_BITS = 10,
  parameter int unsigned PTE_BYTES    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [`XLEN-13:0]  satp_ppn,
  input  logic               tlb_miss_valid,
  input  logic [`XLEN-13:0]  tlb_miss_vpn,
  output logic               tlb_miss_ready,
  output logic               tlb_update_valid,
  output logic [`XLEN-13:0]  tlb_update_vpn,
  output logic [`XLEN-13:0]  tlb_update_ppn,
  input  logic               tlb_update_ready,
  output logic               mem_req_valid,
  output logic [`XLEN-1:0]   mem_req_addr,
  input  logic               mem_req_ready,
  input  logic               mem_rsp_valid,
  input  logic [31:0]        mem_rsp_data,
  output logic               mem_rsp_ready,
  output logic               fault_valid,
  output logic [`XLEN-13:0]  fault_vpn,
  output logic               busy
);

  localparam int unsigned XLEN    = `XLEN;
  localparam int unsigned PPN_W   = XLEN - 12;
  localparam int unsigned LVL_W   = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int unsigned PTE_SHF = $clog2(PTE_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    UPDATE,
    FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [PPN_W-1:0]   vpn_q, vpn_d;
  logic [PPN_W-1:0]   base_q, base_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               mem_req_valid_q, mem_req_valid_d;
  logic [XLEN-1:0]    mem_req_addr_q, mem_req_addr_d;
  logic               tlb_update_valid_q, tlb_update_valid_d;
  logic [PPN_W-1:0]   tlb_update_vpn_q, tlb_update_vpn_d;
  logic [PPN_W-1:0]   tlb_update_ppn_q, tlb_update_ppn_d;
  logic               fault_valid_q, fault_valid_d;
  logic [PPN_W-1:0]   fault_vpn_q, fault_vpn_d;

  logic [PPN_W-1:0]   pte_ppn;
  logic               pte_v, pte_r, pte_w, pte_x, pte_leaf;
  logic               misaligned;
  logic [PPN_W-1:0]   leaf_ppn;
  logic               unused_pte_bits;

  // PTE address for a given table base, VPN and level
  function automatic logic [XLEN-1:0] pte_addr(input logic [PPN_W-1:0] base,
                                               input logic [PPN_W-1:0] vpn,
                                               input logic [LVL_W-1:0] lvl);
    logic [VPN_SEG_BITS-1:0] seg;
    seg = '0;
    for (int unsigned i = 0; i < LEVELS; i++) begin
      if (i == 32'(lvl)) seg = vpn[i*VPN_SEG_BITS +: VPN_SEG_BITS];
    end
    return {base, 12'b0} + (XLEN'(seg) << PTE_SHF);
  endfunction

  assign pte_ppn  = mem_rsp_data[XLEN-3:10];
  assign pte_v    = mem_rsp_data[0];
  assign pte_r    = mem_rsp_data[1];
  assign pte_w    = mem_rsp_data[2];
  assign pte_x    = mem_rsp_data[3];
  assign pte_leaf = pte_r | pte_x;
  assign unused_pte_bits = ^{mem_rsp_data[31:XLEN-2], mem_rsp_data[9:4]};

  // Superpage alignment check and VPN fill of the low PPN segments
  always_comb begin
    misaligned = 1'b0;
    leaf_ppn   = pte_ppn;
    for (int unsigned j = 0; j < LEVELS; j++) begin
      if (j < 32'(level_q)) begin
        if (pte_ppn[j*VPN_SEG_BITS +: VPN_SEG_BITS] != '0) misaligned = 1'b1;
        leaf_ppn[j*VPN_SEG_BITS +: VPN_SEG_BITS] = vpn_q[j*VPN_SEG_BITS +: VPN_SEG_BITS];
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    vpn_d              = vpn_q;
    base_d             = base_q;
    level_d            = level_q;
    mem_req_valid_d    = mem_req_valid_q;
    mem_req_addr_d     = mem_req_addr_q;
    tlb_update_valid_d = tlb_update_valid_q;
    tlb_update_vpn_d   = tlb_update_vpn_q;
    tlb_update_ppn_d   = tlb_update_ppn_q;
    fault_valid_d      = 1'b0;
    fault_vpn_d        = fault_vpn_q;

    case (state_q)
      IDLE: begin
        if (tlb_miss_valid) begin
          vpn_d           = tlb_miss_vpn;
          base_d          = satp_ppn;
          level_d         = LVL_W'(LEVELS - 1);
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = pte_addr(satp_ppn, tlb_miss_vpn, LVL_W'(LEVELS - 1));
          state_d         = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          if (!pte_v || (!pte_r && pte_w)) begin
            fault_valid_d = 1'b1;
            fault_vpn_d   = vpn_q;
            state_d       = FAULT;
          end else if (pte_leaf) begin
            if (misaligned) begin
              fault_valid_d = 1'b1;
              fault_vpn_d   = vpn_q;
              state_d       = FAULT;
            end else begin
              tlb_update_valid_d = 1'b1;
              tlb_update_vpn_d   = vpn_q;
              tlb_update_ppn_d   = leaf_ppn;
              state_d            = UPDATE;
            end
          end else if (level_q == '0) begin
            fault_valid_d = 1'b1;
            fault_vpn_d   = vpn_q;
            state_d       = FAULT;
          end else begin
            base_d          = pte_ppn;
            level_d         = level_q - 1'b1;
            mem_req_valid_d = 1'b1;
            mem_req_addr_d  = pte_addr(pte_ppn, vpn_q, level_q - 1'b1);
            state_d         = REQ;
          end
        end
      end
      UPDATE: begin
        if (tlb_update_ready) begin
          tlb_update_valid_d = 1'b0;
          state_d            = IDLE;
        end
      end
      FAULT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q            <= IDLE;
      vpn_q              <= '0;
      base_q             <= '0;
      level_q            <= '0;
      mem_req_valid_q    <= 1'b0;
      mem_req_addr_q     <= '0;
      tlb_update_valid_q <= 1'b0;
      tlb_update_vpn_q   <= '0;
      tlb_update_ppn_q   <= '0;
      fault_valid_q      <= 1'b0;
      fault_vpn_q        <= '0;
    end else begin
      state_q            <= state_d;
      vpn_q              <= vpn_d;
      base_q             <= base_d;
      level_q            <= level_d;
      mem_req_valid_q    <= mem_req_valid_d;
      mem_req_addr_q     <= mem_req_addr_d;
      tlb_update_valid_q <= tlb_update_valid_d;
      tlb_update_vpn_q   <= tlb_update_vpn_d;
      tlb_update_ppn_q   <= tlb_update_ppn_d;
      fault_valid_q      <= fault_valid_d;
      fault_vpn_q        <= fault_vpn_d;
    end
  end

  assign tlb_miss_ready   = (state_q == IDLE);
  assign mem_rsp_ready    = (state_q == IDLE) || (state_q == WAIT);
  assign busy             = (state_q != IDLE);
  assign mem_req_valid    = mem_req_valid_q;
  assign mem_req_addr     = mem_req_addr_q;
  assign tlb_update_valid = tlb_update_valid_q;
  assign tlb_update_vpn   = tlb_update_vpn_q;
  assign tlb_update_ppn   = tlb_update_ppn_q;
  assign fault_valid      = fault_valid_q;
  assign fault_vpn        = fault_vpn_q;

endmodule

// File: tb/tb_vx_tlb_ptw.sv
// Directed bench for vx_tlb_ptw: hand-computed Sv32 walks, faults,
// back-pressure and reset mid-walk.
module tb_vx_tlb_ptw;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] satp_ppn;
  logic        tlb_miss_valid;
  logic [19:0] tlb_miss_vpn;
  logic        tlb_miss_ready;
  logic        tlb_update_valid;
  logic [19:0] tlb_update_vpn;
  logic [19:0] tlb_update_ppn;
  logic        tlb_update_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_ready;
  logic        fault_valid;
  logic [19:0] fault_vpn;
  logic        busy;

  int total = 0;
  int bad   = 0;

  vx_tlb_ptw #(.LEVELS(2), .VPN_SEG_BITS(10), .PTE_BYTES(4)) dut (
    .clk(clk), .reset(reset), .satp_ppn(satp_ppn),
    .tlb_miss_valid(tlb_miss_valid), .tlb_miss_vpn(tlb_miss_vpn),
    .tlb_miss_ready(tlb_miss_ready),
    .tlb_update_valid(tlb_update_valid), .tlb_update_vpn(tlb_update_vpn),
    .tlb_update_ppn(tlb_update_ppn), .tlb_update_ready(tlb_update_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_ready(mem_rsp_ready),
    .fault_valid(fault_valid), .fault_vpn(fault_vpn), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_miss(input logic [19:0] vpn);
    tlb_miss_valid = 1'b1;
    tlb_miss_vpn   = vpn;
    tick();
    tlb_miss_valid = 1'b0;
  endtask

  task automatic fire_req(input string tag, input logic [31:0] addr);
    chk({tag, "_reqv"}, 32'(mem_req_valid), 32'd1);
    chk({tag, "_addr"}, mem_req_addr, addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk({tag, "_wait_rspr"}, 32'(mem_rsp_ready), 32'd1);
  endtask

  task automatic give_rsp(input logic [31:0] data);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic take_update(input string tag, input logic [19:0] vpn, input logic [19:0] ppn);
    chk({tag, "_updv"}, 32'(tlb_update_valid), 32'd1);
    chk({tag, "_updvpn"}, 32'(tlb_update_vpn), 32'(vpn));
    chk({tag, "_updppn"}, 32'(tlb_update_ppn), 32'(ppn));
    chk({tag, "_nofault"}, 32'(fault_valid), 32'd0);
    tlb_update_ready = 1'b1;
    tick();
    tlb_update_ready = 1'b0;
    chk({tag, "_upd_done"}, 32'(tlb_update_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(tlb_miss_ready), 32'd1);
  endtask

  task automatic take_fault(input string tag, input logic [19:0] vpn);
    chk({tag, "_fv"}, 32'(fault_valid), 32'd1);
    chk({tag, "_fvpn"}, 32'(fault_vpn), 32'(vpn));
    chk({tag, "_noupd"}, 32'(tlb_update_valid), 32'd0);
    chk({tag, "_noreq"}, 32'(mem_req_valid), 32'd0);
    tick();
    chk({tag, "_fv_pulse"}, 32'(fault_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(tlb_miss_ready), 32'd1);
    chk({tag, "_noupd2"}, 32'(tlb_update_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    satp_ppn = 20'h80000;
    tlb_miss_valid = 1'b0;
    tlb_miss_vpn = '0;
    tlb_update_ready = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_missr", 32'(tlb_miss_ready), 32'd1);
    chk("rst_rspr", 32'(mem_rsp_ready), 32'd1);
    chk("rst_reqv", 32'(mem_req_valid), 32'd0);
    chk("rst_updv", 32'(tlb_update_valid), 32'd0);
    chk("rst_fv", 32'(fault_valid), 32'd0);
    chk("rst_addr", mem_req_addr, 32'd0);
    chk("rst_updppn", 32'(tlb_update_ppn), 32'd0);
    reset = 1'b1;
    tick();

    // two-level walk
    do_miss(20'h12345);
    chk("w2_busy", 32'(busy), 32'd1);
    chk("w2_missr", 32'(tlb_miss_ready), 32'd0);
    fire_req("w2_l1", 32'h80000120);
    give_rsp(32'h20000401);
    fire_req("w2_l0", 32'h80001D14);
    give_rsp(32'h26AF3407);
    take_update("w2", 20'h12345, 20'h9ABCD);

    // superpage leaf at level 1
    do_miss(20'h12345);
    fire_req("sp", 32'h80000120);
    give_rsp(32'h2010000F);
    chk("sp_noreq", 32'(mem_req_valid), 32'd0);
    take_update("sp", 20'h12345, 20'h80745);

    // invalid PTE
    do_miss(20'h12345);
    fire_req("inv", 32'h80000120);
    give_rsp(32'h00000000);
    take_fault("inv", 20'h12345);

    // misaligned superpage
    do_miss(20'h12345);
    fire_req("mis", 32'h80000120);
    give_rsp(32'h2010040F);
    take_fault("mis", 20'h12345);

    // R=0 W=1 reserved encoding
    do_miss(20'h00ABC);
    fire_req("rw", 32'h80000008);
    give_rsp(32'h20000405);
    take_fault("rw", 20'h00ABC);

    // non-leaf at level 0
    do_miss(20'h12345);
    fire_req("nl_l1", 32'h80000120);
    give_rsp(32'h20000401);
    fire_req("nl_l0", 32'h80001D14);
    give_rsp(32'h20000401);
    take_fault("nl", 20'h12345);

    // back-pressure, with satp changing mid-walk
    do_miss(20'h12345);
    satp_ppn = 20'h12345;
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_hold", 32'(mem_req_valid), 32'd1);
      chk("bp_addr_hold", mem_req_addr, 32'h80000120);
      chk("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    fire_req("bp_l1", 32'h80000120);
    give_rsp(32'h20000401);
    fire_req("bp_l0", 32'h80001D14);
    give_rsp(32'h26AF3407);
    tlb_miss_valid = 1'b1;
    tlb_miss_vpn   = 20'h00ABC;
    for (int i = 0; i < 4; i++) begin
      chk("bp_updv_hold", 32'(tlb_update_valid), 32'd1);
      chk("bp_updvpn_hold", 32'(tlb_update_vpn), 32'h12345);
      chk("bp_updppn_hold", 32'(tlb_update_ppn), 32'h9ABCD);
      chk("bp_missr_low", 32'(tlb_miss_ready), 32'd0);
      chk("bp_busy2", 32'(busy), 32'd1);
      tick();
    end
    tlb_update_ready = 1'b1;
    tick();
    tlb_update_ready = 1'b0;
    chk("bp_upd_done", 32'(tlb_update_valid), 32'd0);
    chk("bp_missr_after", 32'(tlb_miss_ready), 32'd1);
    chk("bp_noreq_yet", 32'(mem_req_valid), 32'd0);
    tick();
    tlb_miss_valid = 1'b0;
    // new miss uses the current satp (0x12345), seg1 of 0x00ABC = 2
    fire_req("bp_new", 32'h12345008);

    // reset in WAIT, then stale response in IDLE
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rmw_busy", 32'(busy), 32'd0);
    chk("rmw_missr", 32'(tlb_miss_ready), 32'd1);
    chk("rmw_rspr", 32'(mem_rsp_ready), 32'd1);
    chk("rmw_addr", mem_req_addr, 32'd0);
    give_rsp(32'h26AF3407);
    chk("stale_updv", 32'(tlb_update_valid), 32'd0);
    chk("stale_fv", 32'(fault_valid), 32'd0);
    chk("stale_busy", 32'(busy), 32'd0);
    chk("stale_reqv", 32'(mem_req_valid), 32'd0);
    tick();
    chk("stale_updv2", 32'(tlb_update_valid), 32'd0);
    chk("stale_fv2", 32'(fault_valid), 32'd0);

    satp_ppn = 20'h80000;
    do_miss(20'h12345);
    fire_req("post_l1", 32'h80000120);
    give_rsp(32'h20000401);
    fire_req("post_l0", 32'h80001D14);
    give_rsp(32'h26AF3407);
    take_update("post", 20'h12345, 20'h9ABCD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_tlb_ptw.md
# vx_tlb_ptw

Page-table walker serving the TLB bank's miss/update interface: accepts one missing VPN, performs an Sv32-style multi-level walk over a single-outstanding memory read port, and returns the VPN→PPN translation on the TLB update interface. A walk that ends in an invalid or malformed PTE raises a one-cycle fault pulse and produces no update. It sits between the TLB banks (through an arbiter) and the memory/cache read port.

## Interface
- `XLEN`: global macro, 32; virtual and physical address width.
- `LEVELS`: 2; page-table levels.
- `VPN_SEG_BITS`: 10; VPN bits consumed per level; `LEVELS*VPN_SEG_BITS` must equal `XLEN-12`.
- `PTE_BYTES`: 4; PTE size. PTE index shift is `log2(PTE_BYTES)`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: **synchronous, active-low** (0 = reset), sampled on `clk` rising edge.
- `satp_ppn` in XLEN-12: root page-table PPN. Sampled only at miss acceptance.
- `tlb_miss_valid` in 1, `tlb_miss_vpn` in XLEN-12, `tlb_miss_ready` out 1: miss request channel.
- `tlb_update_valid` out 1, `tlb_update_vpn` out XLEN-12, `tlb_update_ppn` out XLEN-12, `tlb_update_ready` in 1: translation response channel.
- `mem_req_valid` out 1, `mem_req_addr` out XLEN, `mem_req_ready` in 1: PTE read request.
- `mem_rsp_valid` in 1, `mem_rsp_data` in 32, `mem_rsp_ready` out 1: PTE read data.
- `fault_valid` out 1, `fault_vpn` out XLEN-12: one-cycle page-fault pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- PTE fields: V=bit0, R=bit1, W=bit2, X=bit3. The PTE PPN is `pte[XLEN-3:10]` (20 bits); upper PTE bits are ignored. `ppn_seg[i]` = PPN bits `[i*VPN_SEG_BITS +: VPN_SEG_BITS]`.
- FSM states: IDLE, REQ, WAIT, UPDATE, FAULT.
- **IDLE**
  - `tlb_miss_ready=1`.
  - On miss fire: latch vpn, set `base=satp_ppn`, `level=LEVELS-1`, go to REQ.
- **REQ**
  - `mem_req_valid=1`.
  - `mem_req_addr = {base,12'b0} + (vpn_seg[level] << log2(PTE_BYTES))`, computed mod 2^XLEN.
  - Address is held stable until `mem_req_ready`. On fire, go to WAIT.
- **WAIT**
  - `mem_rsp_ready=1`.
  - On `mem_rsp_valid`, decode the PTE in priority order:
    - V=0, or (R=0 and W=1): go to FAULT.
    - Leaf (R or X set) with level>0 and any PTE `ppn_seg[j]!=0` for j<level: misaligned superpage, go to FAULT.
    - Leaf otherwise: `result_ppn` = PTE PPN, with segments j<level replaced by `vpn_seg[j]`. Go to UPDATE.
    - Non-leaf with level==0: go to FAULT.
    - Non-leaf otherwise: `base` = PTE PPN, `level--`, go to REQ.
- **UPDATE**
  - `tlb_update_valid=1` with the latched vpn and `result_ppn`.
  - Values are held stable until `tlb_update_ready`. On fire, go to IDLE.
- **FAULT**
  - `fault_valid=1` and `fault_vpn` = latched vpn, for exactly one cycle. Then go to IDLE.
  - No update is issued.
- Only one walk is in flight; `tlb_miss_ready=0` outside IDLE.
- `mem_rsp_ready=1` also in IDLE. A response arriving in IDLE (stale, e.g. after reset) is consumed and discarded.
- A response arriving in REQ is illegal and ignored.
- `satp_ppn` changes during a walk do not affect that walk.

## Timing
- **Reset** (`reset=0` at an edge):
  - FSM goes to IDLE.
  - All valids are 0: `tlb_update_valid`, `mem_req_valid`, `fault_valid`.
  - `busy=0`, `tlb_miss_ready=1` (combinational from IDLE), `mem_rsp_ready=1`.
  - Data outputs reset to 0.
  - Reset mid-walk abandons the walk with no update or fault.
- **Latency**
  - Miss fire at edge T puts `mem_req_valid` high in the following cycle.
  - A response accepted at edge R puts UPDATE/FAULT outputs, or the next REQ, high in the following cycle.
  - With zero-wait memory, a 2-level hit-free walk takes 1 + 2×(req+rsp) + 1 cycles to update.
- **Handshakes**
  - All channels are valid/ready. Valid never drops, and payload never changes, before fire.
- **Simultaneous events**
  - An update fire in UPDATE and a new miss cannot overlap; the earliest new miss acceptance is the cycle after the update fire.

## Test plan
- **Two-level walk**
  - Stimulus: `satp_ppn=0x80000`, miss vpn 0x12345.
  - Response: req addr 0x80000120. Return 0x20000401; next req addr 0x80001D14. Return 0x26AF3407 → update vpn=0x12345, ppn=0x9ABCD, single cycle with ready=1.
- **Superpage leaf at level 1**
  - Stimulus: same miss, first PTE 0x2010000F.
  - Response: no second request; update ppn=0x80745.
- **Invalid PTE**
  - Stimulus: first PTE 0x00000000.
  - Response: `fault_valid` for 1 cycle with `fault_vpn=0x12345`; no update; `tlb_miss_ready` high the following cycle.
- **Misaligned superpage**
  - Stimulus: first PTE 0x2010040F (ppn0=0x001).
  - Response: fault, no update.
- **Back-pressure**
  - Stimulus: hold `mem_req_ready=0` for 3 cycles, then hold `tlb_update_ready=0` for 4 cycles.
  - Response: addr/update payloads stable throughout; `tlb_miss_ready=0`; `busy=1`; a new miss offered meanwhile is accepted only after the update fires.
- **Reset mid-walk**
  - Stimulus: assert `reset=0` in WAIT. After release, deliver the stale response.
  - Response: no update, no fault; next miss walks normally from `satp_ppn`.
